// File: rtl/neopixel_pkg.sv
// rtl/neopixel_pkg.sv - shared register map, control bits, FSM encoding and GRB slices
package neopixel_pkg;

  // Word offsets, i.e. PADDR[7:2]
  localparam logic [5:0] REG_CTRL       = 6'h00;
  localparam logic [5:0] REG_BRIGHT     = 6'h01;
  localparam logic [5:0] REG_ERR_CLR    = 6'h02;
  localparam logic [5:0] REG_PIXEL_BASE = 6'h10;

  // CTRL write bits
  localparam int CTRL_START     = 0;
  localparam int CTRL_CLEAR_ALL = 1;
  localparam int CTRL_DONE_CLR  = 2;
  localparam int CTRL_IRQ_EN    = 3;

  // CTRL read bits
  localparam int STAT_BUSY   = 0;
  localparam int STAT_DONE   = 1;
  localparam int STAT_ERR    = 2;
  localparam int STAT_IRQ_EN = 3;

  // GRB channel slices, shared with the bit serializer
  localparam int GRB_CH_W  = 8;
  localparam int GRB_G_LSB = 16;
  localparam int GRB_R_LSB = 8;
  localparam int GRB_B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SEND  = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_t;

  // One channel times (bright+1), keeping the top byte of the 17-bit product
  function automatic logic [7:0] scale_ch(input logic [7:0] ch, input logic [7:0] bright);
    logic [16:0] prod;
    prod = {9'd0, ch} * ({9'd0, bright} + 17'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

// File: rtl/neopixel_frame_sequencer_if.sv
// rtl/neopixel_frame_sequencer_if.sv - APB register port plus pixel stream to the serializer
interface neopixel_frame_sequencer_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic [23:0] px_data;
  logic        px_valid;
  logic        px_last;
  logic        px_ready;
  logic        ser_done;
  logic        irq;

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, px_ready, ser_done,
    output PRDATA, PREADY, PSLVERR, px_data, px_valid, px_last, irq
  );

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, px_ready, ser_done,
    input  PRDATA, PREADY, PSLVERR, px_data, px_valid, px_last, irq
  );
endinterface

// File: rtl/neopixel_scale.sv
// rtl/neopixel_scale.sv - combinational per-channel brightness scaler for one GRB word
module neopixel_scale (
  input  logic [23:0] pixel,
  input  logic [7:0]  bright,
  output logic [23:0] scaled
);
  import neopixel_pkg::*;

  assign scaled[GRB_G_LSB +: GRB_CH_W] = scale_ch(pixel[GRB_G_LSB +: GRB_CH_W], bright);
  assign scaled[GRB_R_LSB +: GRB_CH_W] = scale_ch(pixel[GRB_R_LSB +: GRB_CH_W], bright);
  assign scaled[GRB_B_LSB +: GRB_CH_W] = scale_ch(pixel[GRB_B_LSB +: GRB_CH_W], bright);
endmodule

// File: rtl/neopixel_frame_sequencer.sv
// rtl/neopixel_frame_sequencer.sv - APB frame buffer streaming scaled pixels to the serializer
module neopixel_frame_sequencer #(
  parameter int NUM_PIXELS = 8,
  parameter int IDX_W      = 4
) (
  input  logic                        PCLK,
  input  logic                        PRESERN,
  neopixel_frame_sequencer_if.slave   bus
);
  import neopixel_pkg::*;

  // Buffer is padded to a power of two so any idx reads a defined (zero) entry
  localparam int               DEPTH     = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_PIXELS - 1);
  localparam logic [6:0]       NUM_PIX_W = 7'(NUM_PIXELS);

  logic [23:0]      pixel_q [DEPTH];
  logic [7:0]       bright_q;
  logic [7:0]       bright_snap;
  logic             irq_en_q;
  logic             err_q;
  logic             done_q;
  seq_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] scale_idx;
  logic [IDX_W-1:0] pix_idx;
  logic [23:0]      scale_in;
  logic [23:0]      scale_out;
  logic [5:0]       word;
  logic [5:0]       pix_off;
  logic             wr, ctrl_wr, bright_wr, errclr_wr, pix_hit, pix_wr;
  logic             busy, start_cmd;
  logic             unused_bits;

  assign word      = bus.PADDR[7:2];
  assign pix_off   = word - REG_PIXEL_BASE;
  assign pix_hit   = (word >= REG_PIXEL_BASE) && ({1'b0, pix_off} < NUM_PIX_W);
  assign pix_idx   = pix_off[IDX_W-1:0];
  assign wr        = bus.PSEL & bus.PENABLE & bus.PWRITE;
  assign ctrl_wr   = wr && (word == REG_CTRL);
  assign bright_wr = wr && (word == REG_BRIGHT);
  assign errclr_wr = wr && (word == REG_ERR_CLR);
  assign pix_wr    = wr && pix_hit;
  assign busy      = (state_q != ST_IDLE);
  // CLEAR_ALL takes priority over START in the same write
  assign start_cmd = ctrl_wr && bus.PWDATA[CTRL_START] && !bus.PWDATA[CTRL_CLEAR_ALL];

  assign bus.PREADY  = 1'b1;
  assign bus.PSLVERR = 1'b0;
  assign bus.irq     = done_q & irq_en_q;
  assign unused_bits = ^{bus.PADDR[31:8], bus.PADDR[1:0], bus.PWDATA[31:24]};

  // In SEND the scaler looks one pixel ahead so the next word is ready on the handshake edge
  assign scale_idx = (state_q == ST_SEND) ? idx_q + IDX_W'(1) : idx_q;
  assign scale_in  = pixel_q[scale_idx];

  neopixel_scale u_scale (
    .pixel  (scale_in),
    .bright (bright_snap),
    .scaled (scale_out)
  );

  // APB read mux; unmapped and write-only addresses read zero
  always_comb begin
    bus.PRDATA = '0;
    if (pix_hit) begin
      bus.PRDATA = {8'd0, pixel_q[pix_idx]};
    end else begin
      case (word)
        REG_CTRL: begin
          bus.PRDATA[STAT_BUSY]   = busy;
          bus.PRDATA[STAT_DONE]   = done_q;
          bus.PRDATA[STAT_ERR]    = err_q;
          bus.PRDATA[STAT_IRQ_EN] = irq_en_q;
        end
        REG_BRIGHT: bus.PRDATA[7:0] = bright_q;
        default: ;
      endcase
    end
  end

  // Register file: pixel buffer, brightness, IRQ enable and the busy-write error flag
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      for (int i = 0; i < DEPTH; i++) pixel_q[i] <= '0;
      bright_q <= 8'hFF;
      irq_en_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (ctrl_wr)   irq_en_q <= bus.PWDATA[CTRL_IRQ_EN];
      if (bright_wr) bright_q <= bus.PWDATA[7:0];
      if (errclr_wr) err_q    <= 1'b0;
      if (busy) begin
        if ((ctrl_wr && (bus.PWDATA[CTRL_START] || bus.PWDATA[CTRL_CLEAR_ALL])) || pix_wr)
          err_q <= 1'b1;
      end else if (ctrl_wr && bus.PWDATA[CTRL_CLEAR_ALL]) begin
        for (int i = 0; i < DEPTH; i++) pixel_q[i] <= '0;
      end else if (pix_wr) begin
        pixel_q[pix_idx] <= bus.PWDATA[23:0];
      end
    end
  end

  // Frame FSM with registered stream outputs and the DONE flag
  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      bright_snap  <= 8'hFF;
      done_q       <= 1'b0;
      bus.px_data  <= '0;
      bus.px_valid <= 1'b0;
      bus.px_last  <= 1'b0;
    end else begin
      // Placed first so a DONE set later in this block wins over the clear
      if (ctrl_wr && bus.PWDATA[CTRL_DONE_CLR]) done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_cmd) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            bright_snap <= bright_q;
            done_q      <= 1'b0;
          end
        end
        ST_LOAD: begin
          bus.px_data  <= scale_out;
          bus.px_valid <= 1'b1;
          bus.px_last  <= (idx_q == LAST_IDX);
          state_q      <= ST_SEND;
        end
        ST_SEND: begin
          if (bus.px_ready) begin
            if (bus.px_last) begin
              bus.px_valid <= 1'b0;
              state_q      <= ST_DRAIN;
            end else begin
              idx_q       <= idx_q + IDX_W'(1);
              bus.px_data <= scale_out;
              bus.px_last <= ((idx_q + IDX_W'(1)) == LAST_IDX);
            end
          end
        end
        ST_DRAIN: begin
          if (bus.ser_done) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// tb/tb_neopixel_frame_sequencer.sv - randomized self-checking bench for the frame sequencer
module tb_neopixel_frame_sequencer;
  localparam int NP = 8;

  logic PCLK = 1'b0;
  logic PRESERN = 1'b0;
  always #5 PCLK = ~PCLK;

  neopixel_frame_sequencer_if bus();

  neopixel_frame_sequencer #(.NUM_PIXELS(NP), .IDX_W(4)) dut (
    .PCLK    (PCLK),
    .PRESERN (PRESERN),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 1;
  int last_wr_edge = 0;
  logic [23:0] pix_m [NP];
  int bright_m = 255;

  typedef struct { logic [23:0] data; logic last; int edge_n; } hs_t;
  hs_t hs_q[$];
  int stall_viol = 0;
  int drop_viol = 0;
  logic prev_valid = 1'b0, prev_stall = 1'b0, prev_hs_last = 1'b0;
  logic [23:0] prev_data = '0;

  always @(posedge PCLK) cyc <= cyc + 1;

  always @(posedge PCLK) begin
    #1;
    case (ready_mode)
      0: bus.px_ready = 1'b0;
      1: bus.px_ready = 1'b1;
      default: bus.px_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Stream observer between edges: logs handshakes, counts stall and drop violations
  always @(negedge PCLK) begin
    if (!PRESERN) begin
      prev_valid = 1'b0; prev_stall = 1'b0; prev_hs_last = 1'b0;
    end else begin
      if (prev_stall && !(bus.px_valid && bus.px_data == prev_data)) stall_viol++;
      if (prev_valid && !bus.px_valid && !prev_hs_last) drop_viol++;
      if (bus.px_valid && bus.px_ready) hs_q.push_back('{bus.px_data, bus.px_last, cyc + 1});
      prev_hs_last = bus.px_valid && bus.px_ready && bus.px_last;
      prev_stall   = bus.px_valid && !bus.px_ready;
      prev_valid   = bus.px_valid;
      prev_data    = bus.px_data;
    end
  end

  // Scaling rule in plain integer arithmetic
  function automatic logic [23:0] model_scale(input logic [23:0] p, input int b);
    int g, r, bl;
    g  = int'(p[23:16]) * (b + 1) / 256;
    r  = int'(p[15:8])  * (b + 1) / 256;
    bl = int'(p[7:0])   * (b + 1) / 256;
    return {8'(g), 8'(r), 8'(bl)};
  endfunction

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = a; bus.PWDATA = d;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    last_wr_edge = cyc;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = a;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2 d = bus.PRDATA;
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k = 0;
    while (hs_q.size() < n && k < budget) begin
      @(posedge PCLK);
      k++;
    end
    #1;
  endtask

  task automatic pulse_ser_done;
    @(posedge PCLK); #1 bus.ser_done = 1'b1;
    @(posedge PCLK); #1 bus.ser_done = 1'b0;
  endtask

  task automatic load_random_pixels;
    for (int i = 0; i < NP; i++) begin
      pix_m[i] = 24'($urandom);
      apb_write(32'h40 + 32'(4 * i), {8'd0, pix_m[i]});
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    @(posedge PCLK); #1 PRESERN = 1'b0;
    repeat (2) @(posedge PCLK);
    #1 PRESERN = 1'b1;
    for (int i = 0; i < NP; i++) pix_m[i] = '0;
    bright_m = 255;
    apb_read(32'h00, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h0); end
    apb_read(32'h04, d);
    checks++; if (d !== 32'hFF) begin failures++; $display("FAIL reset_bright got=%h exp=%h", d, 32'hFF); end
    apb_read(32'h54, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_pixel5 got=%h exp=0", d); end
    checks++; if (bus.px_valid !== 1'b0 || bus.px_last !== 1'b0 || bus.px_data !== 24'h0 || bus.irq !== 1'b0) begin
      failures++; $display("FAIL reset_outputs valid=%b last=%b data=%h irq=%b exp all 0", bus.px_valid, bus.px_last, bus.px_data, bus.irq);
    end
  endtask

  task automatic test_full_frame;
    logic [31:0] d;
    int base, t;
    ready_mode = 1;
    for (int i = 0; i < NP; i++) begin
      pix_m[i] = 24'(32'h010203 * (i + 1));
      apb_write(32'h40 + 32'(4 * i), {8'd0, pix_m[i]});
    end
    base = hs_q.size();
    apb_write(32'h00, 32'h1);
    t = last_wr_edge;
    wait_hs(base + NP, 100);
    checks++; if (hs_q.size() !== base + NP) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", hs_q.size() - base, NP); end
    for (int i = 0; i < NP && base + i < hs_q.size(); i++) begin
      checks++; if (hs_q[base+i].data !== model_scale(pix_m[i], bright_m) || hs_q[base+i].last !== (i == NP - 1) || hs_q[base+i].edge_n !== t + 2 + i) begin
        failures++; $display("FAIL frame_word%0d got=%h last=%b edge=%0d exp=%h last=%b edge=%0d", i, hs_q[base+i].data, hs_q[base+i].last, hs_q[base+i].edge_n, model_scale(pix_m[i], bright_m), (i == NP - 1), t + 2 + i);
      end
    end
    apb_read(32'h00, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL frame_drain_ctrl got=%h exp=1", d); end
    pulse_ser_done;
    apb_read(32'h00, d);
    checks++; if (d !== 32'h2 || bus.irq !== 1'b0) begin failures++; $display("FAIL frame_done ctrl=%h irq=%b exp ctrl=2 irq=0", d, bus.irq); end
  endtask

  task automatic test_back_pressure;
    logic [31:0] d;
    int base, sv0, dv0;
    bright_m = int'($urandom_range(0, 255));
    apb_write(32'h04, 32'(bright_m));
    load_random_pixels();
    sv0 = stall_viol; dv0 = drop_viol;
    ready_mode = 2;
    base = hs_q.size();
    apb_write(32'h00, 32'h1);
    wait_hs(base + NP, 400);
    ready_mode = 1;
    checks++; if (hs_q.size() !== base + NP) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", hs_q.size() - base, NP); end
    for (int i = 0; i < NP && base + i < hs_q.size(); i++) begin
      checks++; if (hs_q[base+i].data !== model_scale(pix_m[i], bright_m) || hs_q[base+i].last !== (i == NP - 1)) begin
        failures++; $display("FAIL bp_word%0d got=%h/%b exp=%h/%b", i, hs_q[base+i].data, hs_q[base+i].last, model_scale(pix_m[i], bright_m), (i == NP - 1));
      end
    end
    checks++; if (stall_viol !== sv0 || drop_viol !== dv0) begin
      failures++; $display("FAIL bp_stability stall_viol=%0d drop_viol=%0d exp 0 0", stall_viol - sv0, drop_viol - dv0);
    end
    pulse_ser_done;
    apb_write(32'h00, 32'h4);
    apb_read(32'h00, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL bp_done_clr got=%h exp=0", d); end
  endtask

  task automatic test_brightness;
    int base;
    bright_m = 8'h7F;
    apb_write(32'h04, 32'h7F);
    pix_m[0] = 24'hFF8001;
    apb_write(32'h40, 32'hFF8001);
    base = hs_q.size();
    apb_write(32'h00, 32'h1);
    wait_hs(base + NP, 100);
    checks++; if (hs_q.size() < base + 1 || hs_q[base].data !== 24'h7F4000) begin
      failures++; $display("FAIL bright_7f_first got=%h exp=7f4000", (hs_q.size() > base) ? hs_q[base].data : 24'hx);
    end
    for (int i = 1; i < NP && base + i < hs_q.size(); i++) begin
      checks++; if (hs_q[base+i].data !== model_scale(pix_m[i], bright_m)) begin
        failures++; $display("FAIL bright_7f_word%0d got=%h exp=%h", i, hs_q[base+i].data, model_scale(pix_m[i], bright_m));
      end
    end
    pulse_ser_done;
    bright_m = 0;
    apb_write(32'h04, 32'h0);
    base = hs_q.size();
    apb_write(32'h00, 32'h1);
    wait_hs(base + NP, 100);
    checks++; if (hs_q.size() !== base + NP) begin failures++; $display("FAIL bright_0_count got=%0d exp=%0d", hs_q.size() - base, NP); end
    for (int i = 0; i < NP && base + i < hs_q.size(); i++) begin
      checks++; if (hs_q[base+i].data !== 24'h000000) begin failures++; $display("FAIL bright_0_word%0d got=%h exp=0", i, hs_q[base+i].data); end
    end
    pulse_ser_done;
  endtask

  task automatic test_busy;
    logic [31:0] d;
    logic [23:0] old3;
    int base, k;
    bright_m = 255;
    apb_write(32'h04, 32'hFF);
    load_random_pixels();
    ready_mode = 0;
    base = hs_q.size();
    apb_write(32'h00, 32'h1);
    k = 0;
    while (bus.px_valid !== 1'b1 && k < 20) begin @(posedge PCLK); #1; k++; end
    checks++; if (bus.px_valid !== 1'b1) begin failures++; $display("FAIL busy_valid got=%b exp=1", bus.px_valid); end
    old3 = pix_m[3];
    apb_write(32'h4C, 32'hABCDEF);
    apb_write(32'h04, 32'h10);
    apb_write(32'h00, 32'h1);
    apb_read(32'h00, d);
    checks++; if (d !== 32'h5) begin failures++; $display("FAIL busy_err_ctrl got=%h exp=5", d); end
    ready_mode = 1;
    wait_hs(base + NP, 100);
    for (int i = 0; i < NP && base + i < hs_q.size(); i++) begin
      checks++; if (hs_q[base+i].data !== model_scale(pix_m[i], bright_m)) begin
        failures++; $display("FAIL busy_snap_word%0d got=%h exp=%h", i, hs_q[base+i].data, model_scale(pix_m[i], bright_m));
      end
    end
    pulse_ser_done;
    repeat (20) @(posedge PCLK);
    #1;
    checks++; if (hs_q.size() !== base + NP) begin failures++; $display("FAIL busy_no_second_frame words=%0d exp=%0d", hs_q.size() - base, NP); end
    apb_read(32'h00, d);
    checks++; if (d !== 32'h6) begin failures++; $display("FAIL busy_after_ctrl got=%h exp=6", d); end
    apb_read(32'h4C, d);
    checks++; if (d !== {8'd0, old3}) begin failures++; $display("FAIL busy_pixel3 got=%h exp=%h", d, old3); end
    bright_m = 8'h10;
    apb_read(32'h04, d);
    checks++; if (d !== 32'h10) begin failures++; $display("FAIL busy_bright_accepted got=%h exp=10", d); end
    apb_write(32'h08, 32'h0);
    apb_read(32'h00, d);
    checks++; if (d !== 32'h2) begin failures++; $display("FAIL err_clr got=%h exp=2", d); end
    apb_write(32'h00, 32'h4);
  endtask

  task automatic test_clear_start;
    logic [31:0] d;
    int base;
    base = hs_q.size();
    apb_write(32'h00, 32'h3);
    repeat (10) @(posedge PCLK);
    #1;
    checks++; if (hs_q.size() !== base || bus.px_valid !== 1'b0) begin
      failures++; $display("FAIL clear_start_no_frame words=%0d valid=%b exp 0 0", hs_q.size() - base, bus.px_valid);
    end
    for (int i = 0; i < NP; i++) begin
      pix_m[i] = '0;
      apb_read(32'h40 + 32'(4 * i), d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL clear_pixel%0d got=%h exp=0", i, d); end
    end
    pulse_ser_done;
    apb_read(32'h00, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL idle_ser_done_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    int base;
    load_random_pixels();
    apb_write(32'h00, 32'h8);
    ready_mode = 1;
    base = hs_q.size();
    apb_write(32'h00, 32'h9);
    wait_hs(base + NP, 100);
    for (int i = 0; i < NP && base + i < hs_q.size(); i++) begin
      checks++; if (hs_q[base+i].data !== model_scale(pix_m[i], bright_m)) begin
        failures++; $display("FAIL irq_word%0d got=%h exp=%h", i, hs_q[base+i].data, model_scale(pix_m[i], bright_m));
      end
    end
    @(posedge PCLK); #1;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 32'h0; bus.PWDATA = 32'hC;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1; bus.ser_done = 1'b1;
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_before_done got=%b exp=0", bus.irq); end
    @(posedge PCLK); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.ser_done = 1'b0;
    checks++; if (bus.irq !== 1'b1) begin failures++; $display("FAIL irq_rise got=%b exp=1", bus.irq); end
    apb_read(32'h00, d);
    checks++; if (d !== 32'hA) begin failures++; $display("FAIL done_set_wins ctrl=%h exp=a", d); end
    apb_write(32'h00, 32'hC);
    checks++; if (bus.irq !== 1'b0) begin failures++; $display("FAIL irq_fall got=%b exp=0", bus.irq); end
    apb_read(32'h00, d);
    checks++; if (d !== 32'h8) begin failures++; $display("FAIL irq_ctrl_after_clr got=%h exp=8", d); end
  endtask

  task automatic test_reset_mid_frame;
    logic [31:0] d;
    int base;
    load_random_pixels();
    ready_mode = 2;
    base = hs_q.size();
    apb_write(32'h00, 32'h1);
    wait_hs(base + 3, 200);
    @(posedge PCLK); #1 PRESERN = 1'b0;
    @(posedge PCLK); #1 PRESERN = 1'b1;
    checks++; if (bus.px_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid got=%b exp=0", bus.px_valid); end
    for (int i = 0; i < NP; i++) pix_m[i] = '0;
    bright_m = 255;
    ready_mode = 1;
    base = hs_q.size();
    apb_read(32'h00, d);
    checks++; if (d !== 32'h0 || bus.irq !== 1'b0) begin failures++; $display("FAIL midreset_ctrl got=%h irq=%b exp 0 0", d, bus.irq); end
    apb_read(32'h04, d);
    checks++; if (d !== 32'hFF) begin failures++; $display("FAIL midreset_bright got=%h exp=ff", d); end
    for (int i = 0; i < NP; i++) begin
      apb_read(32'h40 + 32'(4 * i), d);
      checks++; if (d !== 32'h0) begin failures++; $display("FAIL midreset_pixel%0d got=%h exp=0", i, d); end
    end
    checks++; if (hs_q.size() !== base) begin failures++; $display("FAIL midreset_stream words=%0d exp=0", hs_q.size() - base); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = '0; bus.PWDATA = '0; bus.ser_done = 1'b0;
    test_reset();
    test_full_frame();
    test_back_pressure();
    test_brightness();
    test_busy();
    test_clear_start();
    test_irq();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/neopixel_frame_sequencer.md
Name: neopixel_frame_sequencer

Overview:
- APB3 slave holding a frame of NUM_PIXELS 24-bit GRB colour words, with a global brightness scale.
- On a START command it streams the brightness-scaled pixels, in index order, over a valid/ready interface.
- The downstream consumer is the single-pixel NeoPixel bit serializer, which drives the strip pin and generates the latch/hold gap.
- Sits directly upstream of that serializer and turns it from a one-pixel driver into a strip driver.

Parameters:
NUM_PIXELS, 8, pixels per frame (1..16)
IDX_W, 4, index width; must satisfy 2^IDX_W >= NUM_PIXELS

Ports:
PCLK  in  1  clock
PRESERN  in  1  reset; synchronous, active-low
PSEL  in  1  APB select
PENABLE  in  1  APB access phase
PWRITE  in  1  APB write
PADDR  in  32  APB address; only [7:2] decoded
PWDATA  in  32  APB write data
PRDATA  out  32  APB read data
PREADY  out  1  tied 1
PSLVERR  out  1  tied 0
px_data  out  24  scaled GRB word to serializer, registered
px_valid  out  1  px_data valid
px_last  out  1  current word is pixel NUM_PIXELS-1
px_ready  in  1  serializer accepts the word
ser_done  in  1  one-cycle pulse from serializer after the final hold gap completes
irq  out  1  level; equals DONE & IRQ_EN

Behaviour:
- Clock and reset: single clock PCLK. Reset PRESERN is synchronous and active-low.
- APB write strobe: wr = PSEL & PENABLE & PWRITE. Zero wait states.
- APB read: PRDATA is combinational from PADDR; unmapped addresses read 0.
- Register map:
  - 0x00 CTRL. Write: bit0 START, bit1 CLEAR_ALL, bit2 DONE_CLR, bit3 IRQ_EN (stored). Read: bit0 BUSY, bit1 DONE, bit2 ERR, bit3 IRQ_EN.
  - 0x04 BRIGHT[7:0].
  - 0x08 ERR_CLR: any write clears ERR.
  - 0x40 + 4*i PIXEL[i][23:0], for i < NUM_PIXELS; upper PRDATA bits are 0.
- Reset values:
  - All PIXEL = 0, BRIGHT = 0xFF, IRQ_EN = 0, DONE = 0, ERR = 0, state = IDLE.
  - Outputs: px_valid = 0, px_last = 0, px_data = 0, irq = 0, idx = 0.
- Scaling: ch_out = (ch * (BRIGHT_snap + 1)) >> 8, applied per 8-bit channel with a 17-bit product. BRIGHT = 0xFF is identity; BRIGHT = 0 gives 0. BRIGHT_snap is captured when START is accepted.
- FSM states: IDLE, LOAD, SEND, DRAIN.
  - IDLE:
    - START write (cycle T) → LOAD at T+1; idx = 0; BRIGHT_snap captured; DONE cleared.
    - CLEAR_ALL zeroes every PIXEL in a single cycle.
    - If CLEAR_ALL and START arrive in the same write, the clear executes and START is ignored.
  - LOAD: px_data <= scale(PIXEL[idx]); px_valid <= 1; px_last <= (idx == NUM_PIXELS-1) → SEND. First px_valid appears at T+2.
  - SEND: hold px_data while px_valid & !px_ready. On a handshake:
    - If px_last: px_valid <= 0 → DRAIN.
    - Otherwise: idx++ and px_data/px_last are loaded with the next scaled pixel on the same edge; px_valid stays 1, so words go back-to-back with no bubble.
  - DRAIN: on ser_done → IDLE and DONE <= 1. ser_done in any other state is ignored.
- BUSY = (state != IDLE).
- Writes while BUSY:
  - START, CLEAR_ALL and PIXEL writes are ignored and set ERR.
  - BRIGHT writes are accepted but do not affect the frame in flight (the snapshot is used).
  - DONE_CLR and IRQ_EN are always honoured.
- DONE_CLR in the same cycle that DONE sets: the set wins.
- Reset mid-frame returns to IDLE with px_valid = 0 on the next edge; the serializer is reset on the same reset net.
- NUM_PIXELS = 1: LOAD asserts px_last immediately.

Decomposition:
- Shared package neopixel_pkg holds:
  - Register offsets: CTRL, BRIGHT, ERR_CLR, PIXEL_BASE.
  - CTRL bit positions.
  - The FSM state encoding (2-bit).
  - GRB channel slice positions.
- The serializer reuses the same GRB slice constants.
- One sub-module, neopixel_scale: combinational 24-bit × 8-bit brightness scaler, instantiated once on the PIXEL[idx] mux output.

Test Plan:
- Reset check: after reset, read 0x00 → 0x0; read 0x04 → 0xFF; px_valid = 0.
- Full frame:
  - Stimulus: write PIXEL[0..7] = 0x010203·(i+1); write 0x00 = 0x1; hold px_ready = 1.
  - Required: 8 consecutive handshakes starting at T+2, in index order, with px_last high only on the 8th word.
  - After a ser_done pulse: DONE = 1; irq stays 0 with IRQ_EN = 0.
- Back-pressure: toggle px_ready randomly → px_data stable while stalled; no word lost or duplicated; px_valid never drops mid-frame.
- Brightness: BRIGHT = 0x7F, PIXEL[0] = 0xFF8001, START → first word 0x7F4000; BRIGHT = 0x00 → 0x000000.
- Busy protection:
  - During SEND: write PIXEL[3] = 0xABCDEF, then START → ERR = 1; PIXEL[3] unchanged; no second frame.
  - Write ERR_CLR → ERR = 0.
- Reset and IRQ:
  - Assert PRESERN = 0 mid-frame for one cycle → IDLE, px_valid = 0, PIXEL all 0.
  - With IRQ_EN = 1 and a completed frame: irq rises the cycle after ser_done and falls after DONE_CLR.
